// File: rtl/nco_param_if.sv
// Control and sample bus for the numerically controlled oscillator.
// master: the block that drives tuning and reads samples.
// slave: the oscillator itself.
interface nco_param_if #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned AMP_W   = 8
);
  logic               clk_en;
  logic               inc_load;
  logic [PHASE_W-1:0] inc_in;
  logic [PHASE_W-1:0] phase_offset;
  logic               phase_sync;
  logic [AMP_W-1:0]   sine_out;
  logic [AMP_W-1:0]   cosine_out;
  logic               out_valid;

  modport master (
    output clk_en, inc_load, inc_in, phase_offset, phase_sync,
    input  sine_out, cosine_out, out_valid
  );

  modport slave (
    input  clk_en, inc_load, inc_in, phase_offset, phase_sync,
    output sine_out, cosine_out, out_valid
  );
endinterface

// File: rtl/nco_param.sv
// Numerically controlled oscillator: phase accumulator, quarter-wave sine table,
// two-stage registered pipeline producing a sine/cosine pair with a valid strobe.
module nco_param #(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 6,
  parameter int unsigned AMP_W   = 8
) (
  input logic        clock,
  input logic        reset_n,
  nco_param_if.slave bus
);

  localparam int unsigned DEPTH   = 1 << LUT_AW;
  localparam int          AMP_MAX = (1 << (AMP_W - 1)) - 1;
  localparam real         PI      = 3.14159265358979323846;
  // Quarter turn: cosine leads sine by 90 degrees.
  localparam logic [PHASE_W-1:0] QUARTER = {2'b01, {(PHASE_W - 2){1'b0}}};

  // Elaboration-time sine via Taylor series; argument stays within [0, pi/2].
  function automatic real sin_taylor(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Table entries sample the first quadrant at bin centres; all entries are
  // positive, so adding 0.5 before truncation rounds half away from zero.
  function automatic logic [AMP_W-1:0] lut_entry(input int k);
    real ang;
    real v;
    ang = PI * real'(2 * k + 1) / real'(1 << (LUT_AW + 2));
    v   = real'(AMP_MAX) * sin_taylor(ang);
    return AMP_W'($rtoi(v + 0.5));
  endfunction

  logic [AMP_W-1:0] lut [DEPTH];

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_lut
    localparam logic [AMP_W-1:0] Entry = lut_entry(k);
    assign lut[k] = Entry;
  end

  // State
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [PHASE_W-1:0] ps_q, ps_d;
  logic [PHASE_W-1:0] pc_q, pc_d;
  logic               v1_q, v1_d;
  logic [AMP_W-1:0]   sine_q, sine_d;
  logic [AMP_W-1:0]   cos_q, cos_d;
  // Stage-2 valid doubles as the out_valid strobe: set only on an enabled edge
  // that loads valid stage-1 data, cleared on every other edge.
  logic               out_valid_q, out_valid_d;

  // Stage-2 combinational decode
  logic [1:0]        s_quad, c_quad;
  logic [LUT_AW-1:0] s_idx, c_idx;
  logic [LUT_AW-1:0] s_addr, c_addr;
  logic [AMP_W-1:0]  s_mag, c_mag;
  logic [AMP_W-1:0]  s_val, c_val;
  logic [PHASE_W-1:0] phase_sum;

  // Quadrant fold: odd quadrants read the table backwards, upper half negates.
  always_comb begin
    s_quad = ps_q[PHASE_W-1 -: 2];
    c_quad = pc_q[PHASE_W-1 -: 2];
    s_idx  = ps_q[PHASE_W-3 -: LUT_AW];
    c_idx  = pc_q[PHASE_W-3 -: LUT_AW];
    s_addr = s_quad[0] ? ~s_idx : s_idx;
    c_addr = c_quad[0] ? ~c_idx : c_idx;
    s_mag  = lut[s_addr];
    c_mag  = lut[c_addr];
    s_val  = s_quad[1] ? -s_mag : s_mag;
    c_val  = c_quad[1] ? -c_mag : c_mag;
  end

  // Phase bits below the table index are truncated, not dithered.
  if (PHASE_W > LUT_AW + 2) begin : g_trunc
    logic unused_lsbs;
    assign unused_lsbs = ^{ps_q[PHASE_W-LUT_AW-3:0], pc_q[PHASE_W-LUT_AW-3:0]};
  end

  // Next-state: sync beats accumulation, increment load is independent of enable.
  always_comb begin
    acc_d       = acc_q;
    inc_d       = inc_q;
    ps_d        = ps_q;
    pc_d        = pc_q;
    v1_d        = v1_q;
    sine_d      = sine_q;
    cos_d       = cos_q;
    out_valid_d = 1'b0;
    phase_sum   = acc_q + bus.phase_offset;

    if (bus.inc_load) begin
      inc_d = bus.inc_in;
    end

    if (bus.phase_sync) begin
      acc_d = '0;
      v1_d  = 1'b0;
    end else if (bus.clk_en) begin
      acc_d       = acc_q + inc_q;
      ps_d        = phase_sum;
      pc_d        = phase_sum + QUARTER;
      v1_d        = 1'b1;
      out_valid_d = v1_q;
      // Output data only moves when real samples arrive; otherwise it holds.
      if (v1_q) begin
        sine_d = s_val;
        cos_d  = c_val;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q       <= '0;
      inc_q       <= '0;
      ps_q        <= '0;
      pc_q        <= '0;
      v1_q        <= 1'b0;
      sine_q      <= '0;
      cos_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      ps_q        <= ps_d;
      pc_q        <= pc_d;
      v1_q        <= v1_d;
      sine_q      <= sine_d;
      cos_q       <= cos_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sine_out   = sine_q;
  assign bus.cosine_out = cos_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_nco_param.sv
// Self-checking bench for nco_param at default parameters.
module tb_nco_param;

  localparam int unsigned PW = 16;
  localparam int unsigned AW = 6;
  localparam int unsigned MW = 8;
  localparam real         PI = 3.14159265358979323846;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  nco_param_if #(.PHASE_W(PW), .AMP_W(MW)) bus ();

  nco_param #(.PHASE_W(PW), .LUT_AW(AW), .AMP_W(MW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: acc, increment, phases captured at enabled edges, held outputs.
  logic [PW-1:0] m_acc;
  logic [PW-1:0] m_inc;
  logic [PW-1:0] m_ph[$];
  logic [MW-1:0] m_sin;
  logic [MW-1:0] m_cos;
  logic          m_vld;

  // Ideal sine/cosine at the centre of the table bin containing ph.
  function automatic logic [MW-1:0] wave(input logic [PW-1:0] ph, input bit use_cos);
    int  idx;
    int  r;
    real ang;
    real v;
    idx = int'(ph >> (PW - 2 - AW));
    ang = 2.0 * PI * (real'(idx) + 0.5) / real'(1 << (AW + 2));
    v   = real'((1 << (MW - 1)) - 1) * (use_cos ? $cos(ang) : $sin(ang));
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(0.5 - v);
    return r[MW-1:0];
  endfunction

  task automatic step(input bit en, input bit load, input logic [PW-1:0] inc,
                      input bit sync, input bit rst);
    logic [PW-1:0] p;
    bus.clk_en     = en;
    bus.inc_load   = load;
    bus.inc_in     = inc;
    bus.phase_sync = sync;
    reset_n        = ~rst;
    @(posedge clock);
    if (rst) begin
      m_acc = '0;
      m_inc = '0;
      m_ph.delete();
      m_sin = '0;
      m_cos = '0;
      m_vld = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (sync) begin
        m_acc = '0;
        m_ph.delete();
      end else if (en) begin
        if (m_ph.size() > 0) begin
          m_sin = wave(m_ph[$], 1'b0);
          m_cos = wave(m_ph[$], 1'b1);
          m_vld = 1'b1;
        end
        p = m_acc + bus.phase_offset;
        m_ph.push_back(p);
        if (m_ph.size() > 2) void'(m_ph.pop_front());
        m_acc = m_acc + m_inc;
      end
      if (load) m_inc = inc;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    total++;
    if (bus.sine_out !== 8'h00) begin
      bad++; $display("FAIL reset_sine got=%h exp=00", bus.sine_out);
    end
    total++;
    if (bus.cosine_out !== 8'h00) begin
      bad++; $display("FAIL reset_cos got=%h exp=00", bus.cosine_out);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_const();
    logic [MW-1:0] es;
    logic [MW-1:0] ec;
    bus.phase_offset = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      es = (i >= 1) ? 8'h02 : 8'h00;
      ec = (i >= 1) ? 8'h7F : 8'h00;
      total++;
      if (bus.out_valid !== (i >= 1)) begin
        bad++; $display("FAIL const_valid edge=%0d got=%b exp=%b", i + 1, bus.out_valid, i >= 1);
      end
      total++;
      if (bus.sine_out !== es) begin
        bad++; $display("FAIL const_sine edge=%0d got=%h exp=%h", i + 1, bus.sine_out, es);
      end
      total++;
      if (bus.cosine_out !== ec) begin
        bad++; $display("FAIL const_cos edge=%0d got=%h exp=%h", i + 1, bus.cosine_out, ec);
      end
    end
  endtask

  task automatic test_offset();
    bus.phase_offset = 16'h8000;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (bus.sine_out !== 8'hFE || bus.cosine_out !== 8'h81) begin
      bad++; $display("FAIL offset_8000 got=%h/%h exp=fe/81", bus.sine_out, bus.cosine_out);
    end
    bus.phase_offset = 16'h4000;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (bus.sine_out !== 8'h7F || bus.cosine_out !== 8'hFE) begin
      bad++; $display("FAIL offset_4000 got=%h/%h exp=7f/fe", bus.sine_out, bus.cosine_out);
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL offset_valid got=%b exp=1", bus.out_valid);
    end
    bus.phase_offset = '0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_sweep();
    step(1'b1, 1'b1, 16'h0100, 1'b1, 1'b0);
    for (int i = 0; i < 520; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if (bus.sine_out !== m_sin || bus.cosine_out !== m_cos || bus.out_valid !== m_vld) begin
        bad++;
        $display("FAIL sweep edge=%0d got=%h/%h/%b exp=%h/%h/%b", i, bus.sine_out,
                 bus.cosine_out, bus.out_valid, m_sin, m_cos, m_vld);
      end
    end
  endtask

  task automatic test_clk_en();
    bit            pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [MW-1:0] got[$];
    logic [MW-1:0] exp_s;
    step(1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
    for (int i = 0; i < 80; i++) begin
      step(pat[i % 4], 1'b0, '0, 1'b0, 1'b0);
      if (bus.out_valid === 1'b1) got.push_back(bus.sine_out);
      total++;
      if (bus.sine_out !== m_sin || bus.cosine_out !== m_cos || bus.out_valid !== m_vld) begin
        bad++;
        $display("FAIL clken edge=%0d en=%b got=%h/%h/%b exp=%h/%h/%b", i, pat[i % 4],
                 bus.sine_out, bus.cosine_out, bus.out_valid, m_sin, m_cos, m_vld);
      end
    end
    // Gated run must produce the same sequence as a free-running one.
    total++;
    if (got.size() != 39) begin
      bad++; $display("FAIL clken_count got=%0d exp=39", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      exp_s = wave(16'(k * 256), 1'b0);
      total++;
      if (got[k] !== exp_s) begin
        bad++; $display("FAIL clken_seq k=%0d got=%h exp=%h", k, got[k], exp_s);
      end
    end
  endtask

  task automatic test_sync_load();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0300, 1'b1, 1'b0);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL sync_valid0 got=%b exp=0", bus.out_valid);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL sync_valid1 got=%b exp=0", bus.out_valid);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.sine_out !== 8'h02 || bus.cosine_out !== 8'h7F) begin
      bad++; $display("FAIL sync_first got=%b/%h/%h exp=1/02/7f", bus.out_valid,
                      bus.sine_out, bus.cosine_out);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    total++;
    if (bus.sine_out !== wave(16'h0300, 1'b0)) begin
      bad++; $display("FAIL sync_newinc got=%h exp=%h", bus.sine_out, wave(16'h0300, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b1, 16'h0500, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0777, 1'b1, 1'b1);
    total++;
    if (bus.sine_out !== 8'h00 || bus.cosine_out !== 8'h00 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_zero got=%h/%h/%b exp=00/00/0", bus.sine_out,
                      bus.cosine_out, bus.out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      total++;
      if (bus.out_valid !== (i >= 1)) begin
        bad++; $display("FAIL rstmid_valid edge=%0d got=%b exp=%b", i + 1, bus.out_valid, i >= 1);
      end
      if (i >= 1) begin
        total++;
        if (bus.sine_out !== 8'h02 || bus.cosine_out !== 8'h7F) begin
          bad++; $display("FAIL rstmid_const edge=%0d got=%h/%h exp=02/7f", i + 1,
                          bus.sine_out, bus.cosine_out);
        end
      end
    end
  endtask

  task automatic test_random();
    bit            en, ld, sy, rs;
    logic [PW-1:0] inc;
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 9) < 7);
      ld  = ($urandom_range(0, 9) == 0);
      sy  = ($urandom_range(0, 39) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      inc = PW'($urandom);
      if ($urandom_range(0, 19) == 0) bus.phase_offset = PW'($urandom);
      step(en, ld, inc, sy, rs);
      total++;
      if (bus.sine_out !== m_sin || bus.cosine_out !== m_cos || bus.out_valid !== m_vld) begin
        bad++;
        $display("FAIL random cyc=%0d en=%b ld=%b sy=%b rs=%b got=%h/%h/%b exp=%h/%h/%b",
                 i, en, ld, sy, rs, bus.sine_out, bus.cosine_out, bus.out_valid,
                 m_sin, m_cos, m_vld);
      end
    end
  endtask

  initial begin
    bus.clk_en       = 1'b0;
    bus.inc_load     = 1'b0;
    bus.inc_in       = '0;
    bus.phase_offset = '0;
    bus.phase_sync   = 1'b0;
    m_acc = '0;
    m_inc = '0;
    m_sin = '0;
    m_cos = '0;
    m_vld = 1'b0;
    test_reset();
    test_const();
    test_offset();
    test_sweep();
    test_clk_en();
    test_sync_load();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_param.md
NCO_PARAM -- requirements
Module: nco_param

Interface
REQ-001 SHALL have parameter PHASE_W, default 16, phase accumulator width in bits (legal 10..32).
REQ-002 SHALL have parameter LUT_AW, default 6, quarter-wave table address width; table depth 2^LUT_AW (legal 4..10, LUT_AW+2 <= PHASE_W).
REQ-003 SHALL have parameter AMP_W, default 8, signed output width (legal 4..16).
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clk_en  input  1  advances accumulator and pipeline when 1.
REQ-007 SHALL have port inc_load  input  1  captures inc_in into increment register.
REQ-008 SHALL have port inc_in  input  PHASE_W  new phase increment, unsigned.
REQ-009 SHALL have port phase_offset  input  PHASE_W  static phase offset added after accumulator, unsigned.
REQ-010 SHALL have port phase_sync  input  1  clears accumulator and pipeline valids.
REQ-011 SHALL have port sine_out  output  AMP_W  signed two's-complement sine sample, registered.
REQ-012 SHALL have port cosine_out  output  AMP_W  signed two's-complement cosine sample, registered.
REQ-013 SHALL have port out_valid  output  1  one-cycle strobe: new sample pair on sine_out/cosine_out.

Function
REQ-014 SHALL hold increment register inc_reg (PHASE_W); inc_load=1 loads inc_in at the edge, regardless of clk_en.
REQ-015 SHALL update accumulator acc <= (acc + inc_reg) mod 2^PHASE_W on each edge with clk_en=1; a same-cycle inc_load takes effect from the next enabled edge.
REQ-016 SHALL give phase_sync priority over accumulation: acc <= 0 at that edge irrespective of clk_en.
REQ-017 SHALL form stage-1 phases ps = (acc + phase_offset) mod 2^PHASE_W and pc = (ps + 2^(PHASE_W-2)) mod 2^PHASE_W, registered when clk_en=1.
REQ-018 SHALL take q = top 2 bits and i = next LUT_AW bits of each stage-1 phase; discard remaining LSBs (truncation, no dither).
REQ-019 SHALL map quadrant: q=0 addr=i, +; q=1 addr=~i, +; q=2 addr=i, -; q=3 addr=~i, -.
REQ-020 SHALL contain table LUT[k] = round(A*sin(pi*(2k+1)/2^(LUT_AW+2))), A = 2^(AMP_W-1)-1, round half away from zero, fixed at elaboration.
REQ-021 SHALL register stage-2 outputs sine_out/cosine_out = +/-LUT[addr] when clk_en=1; negation never overflows since |LUT| <= A.
REQ-022 SHALL have latency 2 enabled edges: sample on outputs after enabled edge n reflects acc value held before enabled edge n-1.
REQ-023 SHALL carry a valid bit per stage; stage-1 valid sets on enabled edge, stage-2 valid copies it on enabled edge; out_valid = 1 for exactly the cycle after each enabled edge that loads valid stage-2 data, else 0.
REQ-024 SHALL clear both stage valids on phase_sync, so out_valid stays 0 until two enabled edges after sync; output data registers hold their last values.
REQ-025 SHALL hold all state unchanged when clk_en=0, except inc_reg (REQ-014) and sync (REQ-016).
REQ-026 SHALL have no combinational path from any input to any output.

Reset
REQ-027 SHALL, on an edge with reset_n=0, set acc=0, inc_reg=0, stage registers=0, valids=0, sine_out=0, cosine_out=0, out_valid=0; reset overrides inc_load, phase_sync and clk_en.
REQ-028 SHALL restart from REQ-027 state when reset asserts mid-operation; first out_valid after release occurs two enabled edges after release.

Verification (defaults: PHASE_W=16, LUT_AW=6, AMP_W=8, A=127, LUT[0]=2, LUT[63]=127)
REQ-029 SHALL test: reset, inc=0, offset=0, clk_en=1 constantly -> out_valid first 1 in cycle after 2nd enabled edge; sine_out=+2, cosine_out=+127 thereafter.
REQ-030 SHALL test: offset=0x8000, inc=0 -> sine_out=-2, cosine_out=-127; offset=0x4000 -> sine_out=+127, cosine_out=-2.
REQ-031 SHALL test: inc=0x0100, clk_en=1 -> sine_out walks LUT[0..63] then mirror, negative half, period 256 samples; acc wraps 0xFF00->0x0000 seamlessly.
REQ-032 SHALL test: clk_en toggled 1,0,0,1 -> acc and outputs frozen during 0s; out_valid only after enabled edges; sample sequence identical to clk_en=1 run.
REQ-033 SHALL test: phase_sync and inc_load same edge, mid-run -> acc=0, new inc used from next enabled edge, out_valid=0 for two enabled edges, then sine_out=+2.
REQ-034 SHALL test: reset_n=0 for one edge mid-run with clk_en=1 -> all outputs 0 next cycle, inc_reg=0, output constant +2/+127 after refill.
